// File: rtl/bulb_pkg.sv
// Shared types and constants for the bulb PWM driver.
package bulb_pkg;

    localparam int unsigned PWM_PERIOD = 15;

    typedef enum logic [1:0] {
        WHITE = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        StOff,
        StRampUp,
        StOn,
        StRampDown
    } state_e;

    // Bit order {green, blue, red, white} matches the colour encoding.
    function automatic logic [3:0] color_onehot(input color_e c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/bulb_pwm_gen.sv
// Free-running period-15 PWM generator; output is registered after the compare.
module bulb_pwm_gen
    import bulb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] level,
    output logic       pwm
);

    logic [3:0] cnt_q, cnt_d;
    logic       pwm_q;

    always_comb begin
        cnt_d = (cnt_q == 4'(PWM_PERIOD - 1)) ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            // Level 15 exceeds every count (always on), level 0 none (always off).
            pwm_q <= (level > cnt_q);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/bulb_pwm_driver.sv
// Single-colour bulb driver with optional brightness fading.
// Define BULB_FADE_EN to enable the prescaler and ramp states; otherwise level jumps to target.
module bulb_pwm_driver
    import bulb_pkg::*;
#(
    parameter int unsigned FADE_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       on_off,
    input  logic [3:0] brightness,
    input  logic [1:0] color,
    output logic       led_w,
    output logic       led_r,
    output logic       led_b,
    output logic       led_g,
    output logic [3:0] level,
    output logic       busy
);

    logic       on_q;
    logic [3:0] bri_q;
    color_e     col_q;

    state_e     state_q, state_d;
    logic [3:0] level_q, level_d;
    color_e     act_q, act_d;

    logic [3:0] target;
    logic       pwm;
    logic [3:0] chan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q  <= 1'b0;
            bri_q <= 4'd0;
            col_q <= WHITE;
        end else begin
            on_q  <= on_off;
            bri_q <= brightness;
            col_q <= color_e'(color);
        end
    end

    assign target = (on_q && (bri_q != 4'd0)) ? bri_q : 4'd0;

`ifdef BULB_FADE_EN
    logic [7:0] presc_q;
    logic       tick;
    logic       mismatch;

    assign tick     = (presc_q == 8'(FADE_DIV - 1));
    assign mismatch = (col_q != act_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 8'd0;
        end else begin
            presc_q <= tick ? 8'd0 : presc_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        act_d   = act_q;
        case (state_q)
            StOff: begin
                level_d = 4'd0;
                if (target != 4'd0) begin
                    act_d   = col_q;
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (mismatch || (target < level_q)) begin
                    state_d = StRampDown;
                end else if (level_q == target) begin
                    state_d = (target == 4'd0) ? StOff : StOn;
                end else if (tick) begin
                    level_d = level_q + 4'd1;
                end
            end
            StOn: begin
                if (mismatch || (target < level_q)) begin
                    state_d = StRampDown;
                end else if (target > level_q) begin
                    state_d = StRampUp;
                end else if (level_q == 4'd0) begin
                    state_d = StOff;
                end
            end
            StRampDown: begin
                // The colour may only change once the lamp is fully dark.
                if (level_q == 4'd0) begin
                    if (target != 4'd0) begin
                        act_d   = col_q;
                        state_d = StRampUp;
                    end else begin
                        state_d = StOff;
                    end
                end else if (!mismatch && (level_q == target)) begin
                    state_d = StOn;
                end else if (!mismatch && (target > level_q)) begin
                    state_d = StRampUp;
                end else if (tick) begin
                    level_d = level_q - 4'd1;
                end
            end
            default: state_d = StOff;
        endcase
    end

    assign busy = (state_q == StRampUp) || (state_q == StRampDown);
`else
    always_comb begin
        state_d = (target != 4'd0) ? StOn : StOff;
        level_d = target;
        act_d   = col_q;
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            level_q <= 4'd0;
            act_q   <= WHITE;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            act_q   <= act_d;
        end
    end

    bulb_pwm_gen u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .level (level_q),
        .pwm   (pwm)
    );

    // Only the active channel can carry the PWM, so two leds are never lit at once.
    assign chan  = color_onehot(act_q) & {4{pwm & (state_q != StOff)}};
    assign led_w = chan[0];
    assign led_r = chan[1];
    assign led_b = chan[2];
    assign led_g = chan[3];
    assign level = level_q;

endmodule

// File: tb/tb_bulb_pwm_driver.sv
// Scoreboard bench for bulb_pwm_driver; expectations follow the BULB_FADE_EN setting.
module tb_bulb_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       on_off = 1'b0;
    logic [3:0] brightness = 4'd0;
    logic [1:0] color = 2'd0;
    logic       led_w, led_r, led_b, led_g;
    logic [3:0] level;
    logic       busy;
    logic [3:0] leds;

    typedef struct {
        string      name;
        bit         chk_level;
        logic [3:0] level;
        bit         chk_leds;
        logic [3:0] leds;
        bit         chk_busy;
        logic       busy;
        bit         chk_duty;
        int         duty_w, duty_r, duty_b, duty_g;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] cap = 4'd15;
    logic [3:0] hist[15];

    bulb_pwm_driver #(.FADE_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .on_off     (on_off),
        .brightness (brightness),
        .color      (color),
        .led_w      (led_w),
        .led_r      (led_r),
        .led_b      (led_b),
        .led_g      (led_g),
        .level      (level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign leds = {led_g, led_b, led_r, led_w};

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active clock edge.
    initial begin
        exp_t e;
        int   cnt[4];
        for (int i = 0; i < 15; i++) hist[i] = 4'd0;
        forever begin
            @(negedge clk);
            for (int i = 14; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = leds;
            cmp("onehot", 8'($countones(leds) <= 1), 8'd1);
            cmp("level_cap", 8'(level > cap), 8'd0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk_level) cmp({e.name, ".level"}, 8'(level), 8'(e.level));
                if (e.chk_leds)  cmp({e.name, ".leds"}, 8'(leds), 8'(e.leds));
                if (e.chk_busy)  cmp({e.name, ".busy"}, 8'(busy), 8'(e.busy));
                if (e.chk_duty) begin
                    for (int c = 0; c < 4; c++) begin
                        cnt[c] = 0;
                        for (int i = 0; i < 15; i++) cnt[c] += int'(hist[i][c]);
                    end
                    cmp({e.name, ".duty_w"}, 8'(cnt[0]), 8'(e.duty_w));
                    cmp({e.name, ".duty_r"}, 8'(cnt[1]), 8'(e.duty_r));
                    cmp({e.name, ".duty_b"}, 8'(cnt[2]), 8'(e.duty_b));
                    cmp({e.name, ".duty_g"}, 8'(cnt[3]), 8'(e.duty_g));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Flags: bit2 level, bit1 leds, bit0 busy.
    task automatic chk(input string nm, input logic [2:0] f, input logic [3:0] lv,
                       input logic [3:0] ld, input logic bz);
        exp_t e;
        e.name = nm;
        e.chk_level = f[2]; e.level = lv;
        e.chk_leds  = f[1]; e.leds  = ld;
        e.chk_busy  = f[0]; e.busy  = bz;
        e.chk_duty = 1'b0;
        e.duty_w = 0; e.duty_r = 0; e.duty_b = 0; e.duty_g = 0;
        exp_q.push_back(e);
    endtask

    task automatic chk_duty(input string nm, input logic [3:0] lv,
                            input int w, input int r, input int b, input int g);
        exp_t e;
        e.name = nm;
        e.chk_level = 1'b1; e.level = lv;
        e.chk_leds  = 1'b0; e.leds  = 4'd0;
        e.chk_busy  = 1'b1; e.busy  = 1'b0;
        e.chk_duty = 1'b1;
        e.duty_w = w; e.duty_r = r; e.duty_b = b; e.duty_g = g;
        exp_q.push_back(e);
    endtask

    // Bounded wait for a settled level; a timeout shows up in the next check.
    task automatic wait_level(input logic [3:0] lv, input int bound);
        int n;
        n = 0;
        while ((level !== lv || busy !== 1'b0) && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    task automatic drive(input logic on, input logic [3:0] bri, input logic [1:0] col);
        on_off = on;
        brightness = bri;
        color = col;
    endtask

    initial begin
        tick(2);
        chk("reset", 3'b111, 4'd0, 4'd0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("idle", 3'b111, 4'd0, 4'd0, 1'b0);

        // Off -> full red.
        drive(1'b1, 4'd15, 2'd1);
`ifdef BULB_FADE_EN
        tick(3);
        chk("ramp_start", 3'b001, 4'd0, 4'd0, 1'b1);
        wait_level(4'd15, 400);
`else
        chk("lat0", 3'b101, 4'd0, 4'd0, 1'b0);
        tick(1);
        chk("lat1", 3'b101, 4'd0, 4'd0, 1'b0);
        tick(1);
        chk("lat2", 3'b111, 4'd15, 4'd0, 1'b0);
        tick(1);
        chk("lat3", 3'b111, 4'd15, 4'b0010, 1'b0);
`endif
        tick(20);
        chk_duty("red_full", 4'd15, 0, 15, 0, 0);

        // Colour change at full brightness.
        drive(1'b1, 4'd15, 2'd2);
        tick(3);
`ifdef BULB_FADE_EN
        chk("recolor_busy", 3'b001, 4'd0, 4'd0, 1'b1);
`else
        chk("recolor", 3'b111, 4'd15, 4'b0100, 1'b0);
`endif
        wait_level(4'd15, 500);
        tick(20);
        chk_duty("blue_full", 4'd15, 0, 0, 15, 0);

        drive(1'b1, 4'd5, 2'd2);
        tick(3);
        wait_level(4'd5, 400);
        tick(20);
        chk_duty("blue_5", 4'd5, 0, 0, 5, 0);

        // Brightness 0 with on_off high means off.
        drive(1'b1, 4'd0, 2'd2);
        tick(3);
        wait_level(4'd0, 400);
        tick(3);
        chk("bri0_off", 3'b111, 4'd0, 4'd0, 1'b0);

        // Switch off in the middle of a ramp.
        drive(1'b1, 4'd15, 2'd3);
`ifdef BULB_FADE_EN
        begin
            int n;
            n = 0;
            while (level !== 4'd7 && n < 200) begin
                tick(1);
                n++;
            end
        end
        chk("up_at7", 3'b101, 4'd7, 4'd0, 1'b1);
        cap = 4'd7;
        drive(1'b0, 4'd15, 2'd3);
        tick(3);
        chk("down_busy", 3'b001, 4'd0, 4'd0, 1'b1);
        wait_level(4'd0, 200);
        tick(3);
        chk("down_off", 3'b111, 4'd0, 4'd0, 1'b0);
        cap = 4'd15;
`else
        tick(3);
        chk("green_on", 3'b111, 4'd15, 4'b1000, 1'b0);
        drive(1'b0, 4'd15, 2'd3);
        tick(3);
        chk("green_off", 3'b111, 4'd0, 4'd0, 1'b0);
`endif

        // Asynchronous reset from full red.
        drive(1'b1, 4'd15, 2'd1);
        tick(3);
        wait_level(4'd15, 400);
        tick(3);
        chk("pre_rst", 3'b111, 4'd15, 4'b0010, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 3'b111, 4'd0, 4'd0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_e1", 3'b111, 4'd0, 4'd0, 1'b0);
        tick(1);
`ifdef BULB_FADE_EN
        chk("post_rst_e2", 3'b101, 4'd0, 4'd0, 1'b1);
`else
        chk("post_rst_e2", 3'b101, 4'd15, 4'd0, 1'b0);
`endif
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bulb_pwm_driver.md
BULB_PWM_DRIVER -- requirements
Module: bulb_pwm_driver

Interface
REQ-001 SHALL have parameter FADE_DIV, default 4: clock cycles per one-step brightness change; legal range 1..255.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port on_off  input  1: lamp request, wired from the smart_link BULB modport.
REQ-005 SHALL have port brightness  input  4: target level 0..15, wired from the smart_link BULB modport.
REQ-006 SHALL have port color  input  2: 0 WHITE, 1 RED, 2 BLUE, 3 GREEN, wired from the smart_link BULB modport.
REQ-007 SHALL have ports led_w, led_r, led_b, led_g  output  1 each: PWM drive per colour channel.
REQ-008 SHALL have port level  output  4: current applied brightness.
REQ-009 SHALL have port busy  output  1: high while in RAMP_UP or RAMP_DOWN.

Function
REQ-010 SHALL register on_off, brightness and color once on input; all decisions use the registered copies (1-cycle input latency).
REQ-011 SHALL compute target = (on_off && brightness!=0) ? brightness : 0; brightness 0 with on_off=1 is treated as off.
REQ-012 SHALL run a free-running fade prescaler 0..FADE_DIV-1; a step tick occurs when it equals FADE_DIV-1.
REQ-013 SHALL implement states OFF, RAMP_UP, ON, RAMP_DOWN; level changes by exactly +/-1 per tick, only in the ramp states.
REQ-014 OFF: level 0; when target>0, load active colour from registered color and go to RAMP_UP.
REQ-015 RAMP_UP: on tick, increment level; reaching level==target go to ON; if target<level or registered color != active colour, go to RAMP_DOWN.
REQ-016 ON: if colour differs or target<level go to RAMP_DOWN; if target>level go to RAMP_UP.
REQ-017 RAMP_DOWN: on tick, decrement level; at level==target with no colour mismatch go to ON, or to OFF if level==0; at level 0 with colour mismatch and target>0, load new colour and go to RAMP_UP.
REQ-018 SHALL never light more than one led_* output in the same cycle; only the active-colour channel may be high.
REQ-019 SHALL run a PWM counter 0..14 (period 15, free-running); the channel is high when level > counter, so level 15 holds it high and level 0 holds it low.
REQ-020 led_* outputs SHALL be registered (one cycle after the counter/level compare).
REQ-021 Input changes mid-ramp SHALL be re-evaluated every cycle; level never overshoots the current target.

Reset
REQ-022 While rst_n=0, the block SHALL set all led_* to 0, level 0, busy 0, state OFF, active colour WHITE, prescaler 0, PWM counter 0 and registered inputs 0, immediately and regardless of state.
REQ-023 After rst_n deasserts, the first state change SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-024 With macro BULB_FADE_EN defined, the block SHALL provide ramping per REQ-012..REQ-017.
REQ-025 With BULB_FADE_EN undefined, the block SHALL remove the prescaler and ramp states: level = target one cycle after input registration, colour switches in the same cycle, states are OFF/ON only and busy is tied 0.

Structure
REQ-026 Package bulb_pkg SHALL hold color_e (WHITE/RED/BLUE/GREEN), state_e and the constant PWM_PERIOD=15.
REQ-027 The PWM counter and compare SHALL be sub-module bulb_pwm_gen (inputs clk, rst_n, level; output pwm).

Verification (FADE_DIV=4)
REQ-028 Reset: with lamp at level 15 RED, drive rst_n=0 mid-cycle -> all led_* 0 and level 0 without a clock edge.
REQ-029 From OFF, drive on_off=1, brightness=15, color=RED -> level reaches 15 after 15 ticks (about 60 cycles), then ON, led_r constantly 1, other leds 0, busy 0.
REQ-030 In ON at brightness=5, color=BLUE -> led_b high for exactly 5 of every 15 cycles.
REQ-031 In ON at level 15 RED, change color to BLUE -> ramp to 0, then led_b ramps to 15; led_r and led_b never high together.
REQ-032 During RAMP_UP at level 7, drive on_off=0 -> RAMP_DOWN from 7, OFF after 7 ticks, level never exceeds 7.
REQ-033 With BULB_FADE_EN undefined, change brightness 0->15 -> level=15 two cycles after the input change, busy stays 0.
